vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Sequencing controller for the vending machine datapath. It accumulates coin credit from the `in` coin port and accepts a product selection. It drives a req/ack handshake to the product dispenser, then pays change one 5-unit coin per cycle. It sits between the coin/keypad front end and the dispenser mechanism, and supports four products with parameterised prices.

Parameters:
CREDIT_W, 7, width of the credit register
PRICE0, 15, price of item 0 (multiple of 5)
PRICE1, 20, price of item 1 (multiple of 5)
PRICE2, 25, price of item 2 (multiple of 5)
PRICE3, 30, price of item 3 (multiple of 5)
MAX_CREDIT, 60, credit ceiling (multiple of 5, less than 2**CREDIT_W)
ACK_TIMEOUT, 15, cycles to wait for disp_ack before faulting

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
in  in  2  coin code per cycle: 00 none, 01 = 5, 10 = 10, 11 = cancel/refund
sel  in  2  product index
sel_valid  in  1  one-cycle selection strobe
disp_ack  in  1  dispenser completion, one-cycle pulse
disp_req  out  1  dispense request, level
disp_item  out  2  latched product index, valid while disp_req=1
out  out  1  vend-complete pulse
change  out  1  one 5-unit coin returned this cycle
coin_reject  out  1  coin refused pulse
insufficient  out  1  selection refused pulse
fault  out  1  dispenser timeout pulse
credit  out  CREDIT_W  current credit
busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- Reset: all outputs 0, credit=0, state IDLE, timeout counter 0. Reset mid-operation abandons any dispense or change in progress. No refund is owed after reset.
- States and general rules:
  - States are IDLE (credit=0), CREDIT (credit>0), DISPENSE and CHANGE.
  - All outputs are registered.
  - Every response appears the cycle after the causing input edge.
- Coin (01/10) in IDLE or CREDIT:
  - Accept when credit+value ≤ MAX_CREDIT: credit updates next cycle, state goes to CREDIT.
  - Otherwise pulse coin_reject; credit unchanged.
- Coins in DISPENSE or CHANGE are always rejected with coin_reject.
- Selection, when sel_valid is high in IDLE or CREDIT:
  - Compare eff = credit + value of any coin accepted the same cycle (0 for a rejected coin or for cancel) against price[sel].
  - eff ≥ price: credit ← eff − price, disp_item ← sel, disp_req ← 1, go to DISPENSE.
  - Otherwise pulse insufficient. The coin is still accepted if it was legal.
- Cancel (11):
  - In CREDIT: go to CHANGE.
  - In IDLE, DISPENSE or CHANGE: ignored.
  - Cancel together with sel_valid: cancel wins; no selection and no insufficient pulse.
- DISPENSE:
  - disp_req is held high. The timeout counter increments each cycle.
  - On disp_ack: disp_req ← 0, out pulses 1 cycle. Go to CHANGE if credit>0, else IDLE.
  - If the counter reaches ACK_TIMEOUT with no ack: disp_req ← 0, fault pulses, credit ← credit + price of the latched item (full refund), go to CHANGE.
  - disp_ack is ignored outside DISPENSE.
- CHANGE:
  - change=1 for exactly credit/5 consecutive cycles.
  - credit decrements by 5 on each change cycle.
  - Enter IDLE on the cycle credit reaches 0.
  - sel_valid is ignored in CHANGE.
- busy equals (state==DISPENSE or state==CHANGE).
- Width rules: credit is unsigned CREDIT_W bits and never exceeds MAX_CREDIT. Parameter-check that MAX_CREDIT+PRICE3 fits in CREDIT_W, so the refund path cannot overflow.

Decomposition:
- Package vend_pkg holds:
  - coin code constants (COIN_NONE, COIN_5, COIN_10, COIN_CANCEL);
  - COIN_UNIT=5;
  - state enum (IDLE, CREDIT, DISPENSE, CHANGE);
  - a function returning the coin value for a code.
- One natural sub-module, vend_change_unit: it loads a credit value and emits one change pulse per cycle until empty, with a done flag. The controller FSM, price mux and timeout counter live in vend_controller.

Test Plan:
1. Reset, then in=01 at three consecutive edges -> credit 5, 10, 15. Then sel=0 with sel_valid -> disp_req=1, disp_item=0, credit=0. disp_ack 3 cycles later -> out pulse, back to IDLE, no change pulses.
2. Coins 10+10+10 (credit 30), sel=1 -> credit 10 in DISPENSE; ack -> out pulse, then change=1 for exactly 2 cycles, credit 5→0, IDLE.
3. Credit 55, in=10 -> coin_reject, credit stays 55. Then in=01 -> credit 60.
4. Credit 10, sel=2 alone -> insufficient pulse, credit 10. Then in=10 with sel=1 in the same cycle -> accepted (eff 20), DISPENSE, credit 0.
5. Credit 25, sel=3 with in=01 in the same cycle -> dispense, credit 0. No ack for 15 cycles -> fault, disp_req drops, credit 30, 6 change pulses, IDLE. Coins during DISPENSE/CHANGE -> coin_reject.
6. Credit 20, cancel -> 4 change pulses. Assert rst during the 2nd change pulse -> next cycle credit=0, change=0, IDLE, all outputs 0.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending machine sequencing controller.
//   - coin code constants presented on the coin port each cycle
//   - COIN_UNIT, the value of one returned change coin
//   - vend_state_e, the controller state encoding
//   - coin_value(), which maps a coin code to its credit value
package vend_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_5      = 2'b01;
    localparam logic [1:0] COIN_10     = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    localparam int COIN_UNIT = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    // Cancel and "no coin" carry no credit value.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        v = 4'd0;
        case (code)
            COIN_5:  v = 4'd5;
            COIN_10: v = 4'd10;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: signal bundle between the coin/keypad front end, the dispenser
// and the vend controller.
//   in, sel, sel_valid, disp_ack      : front end / dispenser -> controller
//   disp_req, disp_item, out, change,
//   coin_reject, insufficient, fault,
//   credit, busy                      : controller -> outside world
//   state                             : controller FSM state, debug view
// Handshake: disp_req is a level raised by the controller and held until
// the dispenser answers with a one-cycle disp_ack pulse (or the controller
// gives up on timeout); disp_item is stable for as long as disp_req is high.
// The controller uses the slave modport; the environment uses master.
interface vend_if
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 7
);
    logic [1:0]          in;
    logic [1:0]          sel;
    logic                sel_valid;
    logic                disp_ack;
    logic                disp_req;
    logic [1:0]          disp_item;
    logic                out;
    logic                change;
    logic                coin_reject;
    logic                insufficient;
    logic                fault;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    vend_state_e         state;

    modport master (
        output in, sel, sel_valid, disp_ack,
        input  disp_req, disp_item, out, change, coin_reject, insufficient,
               fault, credit, busy, state
    );

    modport slave (
        input  in, sel, sel_valid, disp_ack,
        output disp_req, disp_item, out, change, coin_reject, insufficient,
               fault, credit, busy, state
    );
endinterface

// File: rtl/vend_change_unit.sv
// vend_change_unit: change payout sequencer.
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture load_value as the amount still owed
//   load_value  : amount to pay out (a multiple of COIN_UNIT)
//   change      : registered, high for one cycle per COIN_UNIT paid
//   done        : nothing left to pay
// After a load, change is high on each following cycle until the owed
// amount has been paid out in COIN_UNIT steps.
module vend_change_unit
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_value,
    output logic                change,
    output logic                done
);
    localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(COIN_UNIT);

    logic [CREDIT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            change  <= 1'b0;
        end else if (load) begin
            count_q <= load_value;
            change  <= 1'b0;
        end else if (count_q >= UNIT) begin
            count_q <= count_q - UNIT;
            change  <= 1'b1;
        end else begin
            change  <= 1'b0;
        end
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/vend_controller.sv
// vend_controller: vending machine sequencing controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vend_if slave modport (coin/selection inputs, dispenser
//              handshake, status pulses, credit, busy, debug state)
// Accumulates coin credit, accepts a selection against a four-entry price
// table, runs the disp_req/disp_ack handshake with a timeout that refunds
// the price, and pays change through vend_change_unit. All outputs are
// registered, so every response appears one cycle after the causing edge.
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 7,
    parameter int PRICE0      = 15,
    parameter int PRICE1      = 20,
    parameter int PRICE2      = 25,
    parameter int PRICE3      = 30,
    parameter int MAX_CREDIT  = 60,
    parameter int ACK_TIMEOUT = 15
) (
    input logic   clk,
    input logic   rst,
    vend_if.slave bus
);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W + 1)'(MAX_CREDIT);

    // The fault refund adds a full price back onto remaining credit; the
    // sum must fit the credit register.
    if (MAX_CREDIT + PRICE3 >= (1 << CREDIT_W)) begin : g_width_check
        $error("vend_controller: MAX_CREDIT + PRICE3 does not fit in CREDIT_W bits");
    end

    function automatic logic [CREDIT_W:0] price_of(input logic [1:0] idx);
        logic [CREDIT_W:0] p;
        p = '0;
        case (idx)
            2'd0:    p = (CREDIT_W + 1)'(PRICE0);
            2'd1:    p = (CREDIT_W + 1)'(PRICE1);
            2'd2:    p = (CREDIT_W + 1)'(PRICE2);
            default: p = (CREDIT_W + 1)'(PRICE3);
        endcase
        return p;
    endfunction

    vend_state_e         state_q, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [TMO_W-1:0]    tmo_q, tmo_n;
    logic                disp_req_q, disp_req_n;
    logic [1:0]          disp_item_q, disp_item_n;
    logic                out_q, out_n;
    logic                coin_reject_q, coin_reject_n;
    logic                insufficient_q, insufficient_n;
    logic                fault_q, fault_n;

    logic                is_coin, is_cancel, coin_ok;
    logic [CREDIT_W:0]   sum, eff, price_sel;
    logic                cu_load, cu_change, cu_done;

    // Coin acceptance and the effective credit a same-cycle selection sees.
    assign is_coin   = (bus.in == COIN_5) || (bus.in == COIN_10);
    assign is_cancel = (bus.in == COIN_CANCEL);
    assign sum       = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(bus.in));
    assign coin_ok   = is_coin && (sum <= MAX_W);
    assign eff       = coin_ok ? sum : {1'b0, credit_q};
    assign price_sel = price_of(bus.sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            tmo_q          <= '0;
            disp_req_q     <= 1'b0;
            disp_item_q    <= 2'd0;
            out_q          <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_n;
            credit_q       <= credit_n;
            tmo_q          <= tmo_n;
            disp_req_q     <= disp_req_n;
            disp_item_q    <= disp_item_n;
            out_q          <= out_n;
            coin_reject_q  <= coin_reject_n;
            insufficient_q <= insufficient_n;
            fault_q        <= fault_n;
        end
    end

    always_comb begin
        state_n        = state_q;
        credit_n       = credit_q;
        tmo_n          = tmo_q;
        disp_req_n     = disp_req_q;
        disp_item_n    = disp_item_q;
        out_n          = 1'b0;
        coin_reject_n  = 1'b0;
        insufficient_n = 1'b0;
        fault_n        = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                coin_reject_n = is_coin && !coin_ok;
                if (is_cancel) begin
                    // Cancel overrides any selection; in IDLE nothing is owed.
                    if (state_q == CREDIT) begin
                        state_n = CHANGE;
                    end
                end else if (bus.sel_valid && (eff >= price_sel)) begin
                    credit_n    = CREDIT_W'(eff - price_sel);
                    disp_item_n = bus.sel;
                    disp_req_n  = 1'b1;
                    tmo_n       = '0;
                    state_n     = DISPENSE;
                end else begin
                    credit_n       = CREDIT_W'(eff);
                    insufficient_n = bus.sel_valid;
                    state_n        = (eff != '0) ? CREDIT : IDLE;
                end
            end

            DISPENSE: begin
                coin_reject_n = is_coin;
                if (bus.disp_ack) begin
                    disp_req_n = 1'b0;
                    out_n      = 1'b1;
                    tmo_n      = '0;
                    state_n    = (credit_q != '0) ? CHANGE : IDLE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    // Counter reaches ACK_TIMEOUT on this edge: give up and
                    // refund the latched item's price along with any change.
                    disp_req_n = 1'b0;
                    fault_n    = 1'b1;
                    tmo_n      = '0;
                    credit_n   = CREDIT_W'({1'b0, credit_q} + price_of(disp_item_q));
                    state_n    = CHANGE;
                end else begin
                    tmo_n = tmo_q + 1'b1;
                end
            end

            CHANGE: begin
                coin_reject_n = is_coin;
                // The payout unit emits its pulse on the same edge that this
                // decrement lands, so credit and change stay in step.
                if ((credit_q <= CREDIT_W'(COIN_UNIT)) || cu_done) begin
                    credit_n = '0;
                    state_n  = IDLE;
                end else begin
                    credit_n = credit_q - CREDIT_W'(COIN_UNIT);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Load the payout unit on every entry into CHANGE with the owed amount.
    assign cu_load = (state_n == CHANGE) && (state_q != CHANGE);

    vend_change_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk        (clk),
        .rst        (rst),
        .load       (cu_load),
        .load_value (credit_n),
        .change     (cu_change),
        .done       (cu_done)
    );

    assign bus.disp_req     = disp_req_q;
    assign bus.disp_item    = disp_item_q;
    assign bus.out          = out_q;
    assign bus.change       = cu_change;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.insufficient = insufficient_q;
    assign bus.fault        = fault_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = (state_q == DISPENSE) || (state_q == CHANGE);
    assign bus.state        = state_q;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed self-checking bench for vend_controller.
module tb_vend_controller;
    import vend_pkg::*;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    vend_if #(.CREDIT_W(7)) bus ();

    vend_controller #(
        .CREDIT_W    (7),
        .PRICE0      (15),
        .PRICE1      (20),
        .PRICE2      (25),
        .PRICE3      (30),
        .MAX_CREDIT  (60),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks. Inputs change 1ns after a rising edge; outputs are
    // sampled at that same point, well away from the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] coin, input logic [1:0] s,
                         input logic sv, input logic ack);
        bus.in        = coin;
        bus.sel       = s;
        bus.sel_valid = sv;
        bus.disp_ack  = ack;
    endtask

    task automatic quiet();
        drive(COIN_NONE, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic insert_coin(input logic [1:0] coin, input int exp_credit,
                               input string tag);
        drive(coin, 2'd0, 1'b0, 1'b0);
        tick();
        quiet();
        check(tag, bus.credit, exp_credit);
    endtask

    // Counts change pulses until IDLE, bounded by a cycle budget.
    task automatic drain_change(input string tag, input int exp_pulses);
        int  pulses;
        bit  reached;
        pulses  = 0;
        reached = 1'b0;
        quiet();
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (bus.change) pulses++;
            if (bus.state == IDLE) reached = 1'b1;
        end
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_idle"}, reached, 1);
        check({tag, "_credit"}, bus.credit, 0);
        tick();
        check({tag, "_change_off"}, bus.change, 0);
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        tick();
        tick();
        check("rst_credit", bus.credit, 0);
        check("rst_state", bus.state, IDLE);
        check("rst_req", bus.disp_req, 0);
        check("rst_change", bus.change, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out", bus.out, 0);
        rst = 1'b0;
        tick();

        // 1: three 5-coins, buy item 0, ack after 3 cycles, no change.
        insert_coin(COIN_5, 5, "t1_c5a");
        check("t1_state_credit", bus.state, CREDIT);
        insert_coin(COIN_5, 10, "t1_c5b");
        insert_coin(COIN_5, 15, "t1_c5c");
        drive(COIN_NONE, 2'd0, 1'b1, 1'b0);
        tick();
        quiet();
        check("t1_req", bus.disp_req, 1);
        check("t1_item", bus.disp_item, 0);
        check("t1_credit", bus.credit, 0);
        check("t1_busy", bus.busy, 1);
        tick();
        tick();
        drive(COIN_NONE, 2'd0, 1'b0, 1'b1);
        tick();
        quiet();
        check("t1_out", bus.out, 1);
        check("t1_req_drop", bus.disp_req, 0);
        check("t1_idle", bus.state, IDLE);
        tick();
        check("t1_out_pulse", bus.out, 0);
        check("t1_no_change", bus.change, 0);

        // Ack outside DISPENSE is ignored.
        drive(COIN_NONE, 2'd0, 1'b0, 1'b1);
        tick();
        quiet();
        check("ack_ignored_out", bus.out, 0);

        // 2: 30 credit, buy item 1, 10 change in two pulses.
        insert_coin(COIN_10, 10, "t2_c10a");
        insert_coin(COIN_10, 20, "t2_c10b");
        insert_coin(COIN_10, 30, "t2_c10c");
        drive(COIN_NONE, 2'd1, 1'b1, 1'b0);
        tick();
        quiet();
        check("t2_state", bus.state, DISPENSE);
        check("t2_credit", bus.credit, 10);
        check("t2_item", bus.disp_item, 1);
        drive(COIN_NONE, 2'd0, 1'b0, 1'b1);
        tick();
        quiet();
        check("t2_out", bus.out, 1);
        check("t2_state_change", bus.state, CHANGE);
        check("t2_change_first", bus.change, 0);
        tick();
        check("t2_p1_change", bus.change, 1);
        check("t2_p1_credit", bus.credit, 5);
        tick();
        check("t2_p2_change", bus.change, 1);
        check("t2_p2_credit", bus.credit, 0);
        check("t2_p2_idle", bus.state, IDLE);
        tick();
        check("t2_change_off", bus.change, 0);

        // 3: ceiling. 55 + 10 rejected, 55 + 5 accepted, 60 + 5 rejected.
        for (int i = 1; i <= 5; i++) insert_coin(COIN_10, 10 * i, "t3_fill");
        insert_coin(COIN_5, 55, "t3_55");
        insert_coin(COIN_10, 55, "t3_rej10_credit");
        check("t3_rej10", bus.coin_reject, 1);
        insert_coin(COIN_5, 60, "t3_60");
        check("t3_accept_no_rej", bus.coin_reject, 0);
        insert_coin(COIN_5, 60, "t3_over_credit");
        check("t3_over_rej", bus.coin_reject, 1);
        drive(COIN_CANCEL, 2'd0, 1'b0, 1'b0);
        tick();
        check("t3_cancel_state", bus.state, CHANGE);
        drain_change("t3_refund", 12);

        // 4: insufficient, then a same-cycle coin completes the price.
        insert_coin(COIN_10, 10, "t4_c10");
        drive(COIN_NONE, 2'd2, 1'b1, 1'b0);
        tick();
        quiet();
        check("t4_insuff", bus.insufficient, 1);
        check("t4_insuff_credit", bus.credit, 10);
        check("t4_insuff_state", bus.state, CREDIT);
        drive(COIN_10, 2'd1, 1'b1, 1'b0);
        tick();
        quiet();
        check("t4_req", bus.disp_req, 1);
        check("t4_credit", bus.credit, 0);
        check("t4_item", bus.disp_item, 1);
        check("t4_no_insuff", bus.insufficient, 0);
        drive(COIN_NONE, 2'd0, 1'b0, 1'b1);
        tick();
        quiet();
        check("t4_out", bus.out, 1);
        check("t4_idle", bus.state, IDLE);

        // 5: timeout refund with coins rejected during DISPENSE/CHANGE.
        insert_coin(COIN_10, 10, "t5_c10a");
        insert_coin(COIN_10, 20, "t5_c10b");
        insert_coin(COIN_5, 25, "t5_c5");
        drive(COIN_5, 2'd3, 1'b1, 1'b0);
        tick();
        check("t5_req", bus.disp_req, 1);
        check("t5_item", bus.disp_item, 3);
        check("t5_credit", bus.credit, 0);
        drive(COIN_10, 2'd0, 1'b0, 1'b0);
        tick();
        quiet();
        check("t5_disp_rej", bus.coin_reject, 1);
        check("t5_disp_rej_credit", bus.credit, 0);
        for (int i = 0; i < 13; i++) tick();
        check("t5_no_fault_yet", bus.fault, 0);
        check("t5_req_held", bus.disp_req, 1);
        tick();
        check("t5_fault", bus.fault, 1);
        check("t5_req_drop", bus.disp_req, 0);
        check("t5_refund_credit", bus.credit, 30);
        check("t5_state", bus.state, CHANGE);
        drive(COIN_5, 2'd0, 1'b0, 1'b0);
        tick();
        quiet();
        check("t5_chg_rej", bus.coin_reject, 1);
        check("t5_chg_first", bus.change, 1);
        check("t5_chg_credit", bus.credit, 25);
        check("t5_fault_pulse", bus.fault, 0);
        drain_change("t5_refund", 5);

        // Cancel with a same-cycle selection: cancel wins.
        insert_coin(COIN_10, 10, "cx_c10a");
        insert_coin(COIN_10, 20, "cx_c10b");
        drive(COIN_CANCEL, 2'd0, 1'b1, 1'b0);
        tick();
        quiet();
        check("cx_state", bus.state, CHANGE);
        check("cx_no_req", bus.disp_req, 0);
        check("cx_no_insuff", bus.insufficient, 0);
        drain_change("cx_refund", 4);

        // 6: reset during the second change pulse.
        insert_coin(COIN_10, 10, "t6_c10a");
        insert_coin(COIN_10, 20, "t6_c10b");
        drive(COIN_CANCEL, 2'd0, 1'b0, 1'b0);
        tick();
        quiet();
        tick();
        check("t6_p1", bus.change, 1);
        check("t6_p1_credit", bus.credit, 15);
        tick();
        check("t6_p2", bus.change, 1);
        check("t6_p2_credit", bus.credit, 10);
        rst = 1'b1;
        tick();
        check("t6_rst_credit", bus.credit, 0);
        check("t6_rst_change", bus.change, 0);
        check("t6_rst_state", bus.state, IDLE);
        check("t6_rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();
        check("t6_post_change", bus.change, 0);
        check("t6_post_credit", bus.credit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
